// File: rtl/rf_multiport_sb.sv
`default_nettype none
// ============================================================================
// Module   : rf_multiport_sb
// Purpose  : Multi-read-port register file with two write ports (ALU
//            writeback on port A, load/UART return on port B), optional
//            same-cycle write-to-read bypass and a per-register busy
//            scoreboard tracking outstanding long-latency writes.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            rd_addr/rd_data - NUM_RD packed read ports
//            rd_busy         - per read port: register has a reservation
//            wa_*            - write port A (ALU writeback)
//            wb_*            - write port B (load return, clears busy)
//            rsv_en/rsv_addr - mark a register busy at load issue
//            any_busy        - OR of all stored busy bits
// Revision : 1.0 - initial release
// ============================================================================
module rf_multiport_sb #(
    parameter int              DATA_W   = 32,
    parameter int              NUM_REGS = 32,
    parameter int              ADDR_W   = 5,
    parameter int              NUM_RD   = 3,
    parameter int              SP_IDX   = 2,
    parameter logic [DATA_W-1:0] SP_RESET = 'h0000_0200,
    parameter int              BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     any_busy
);

    logic [DATA_W-1:0]   r_regs_q [NUM_REGS];
    logic [DATA_W-1:0]   w_regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy_q;
    logic [NUM_REGS-1:0] w_busy_d;

    // Next-state. The decode loop starts at 1 and stops below NUM_REGS, so
    // writes/reserves to x0 or to unimplemented indices never match.
    // Statement order encodes priority: wb overrides wa data, and a
    // reservation overrides the busy clear from wb.
    always_comb begin
        w_regs_d = r_regs_q;
        w_busy_d = r_busy_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wa_en && (wa_addr == ADDR_W'(i))) begin
                w_regs_d[i] = wa_data;
            end
            if (wb_en && (wb_addr == ADDR_W'(i))) begin
                w_regs_d[i] = wb_data;
                w_busy_d[i] = 1'b0;
            end
            if (rsv_en && (rsv_addr == ADDR_W'(i))) begin
                w_busy_d[i] = 1'b1;
            end
        end
        w_regs_d[0] = '0;
        w_busy_d[0] = 1'b0;
    end

    // Stack pointer value is reloaded on every reset, not just power-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs_q[i] <= ((i == SP_IDX) && (i != 0)) ? SP_RESET : '0;
            end
            r_busy_q <= '0;
        end else begin
            r_regs_q <= w_regs_d;
            r_busy_q <= w_busy_d;
        end
    end

    assign any_busy = |r_busy_q;

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic              w_valid;
            logic [DATA_W-1:0] w_sdata;
            logic              w_sbusy;
            logic              w_wa_hit;
            logic              w_wb_hit;
            logic [DATA_W-1:0] w_data;

            assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];

            // Stored lookup; x0 and out-of-range indices fall through to
            // zero data, not-busy and an invalid flag that blocks bypass.
            always_comb begin
                w_valid = 1'b0;
                w_sdata = '0;
                w_sbusy = 1'b0;
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (w_addr == ADDR_W'(i)) begin
                        w_valid = 1'b1;
                        w_sdata = r_regs_q[i];
                        w_sbusy = r_busy_q[i];
                    end
                end
            end

            assign w_wb_hit = (BYPASS != 0) && w_valid && wb_en && (wb_addr == w_addr);
            assign w_wa_hit = (BYPASS != 0) && w_valid && wa_en && (wa_addr == w_addr);

            always_comb begin
                w_data = w_sdata;
                if (w_wb_hit) begin
                    w_data = wb_data;
                end else if (w_wa_hit) begin
                    w_data = wa_data;
                end
            end

            assign rd_data[p*DATA_W +: DATA_W] = w_data;
            // A returning load in this cycle satisfies the reservation.
            assign rd_busy[p] = w_sbusy & ~w_wb_hit;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rf_multiport_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_multiport_sb
// Purpose  : Self-checking bench for rf_multiport_sb. Two instances share
//            the stimulus: u_byp (BYPASS=1, 32 regs) and u_nob (BYPASS=0,
//            24 regs, so indices 24..31 are unimplemented).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_multiport_sb;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 4;
    localparam int NR0 = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD*AW-1:0] rd_addr;
    logic              wa_en, wb_en, rsv_en;
    logic [AW-1:0]     wa_addr, wb_addr, rsv_addr;
    logic [DW-1:0]     wa_data, wb_data;

    logic [NRD*DW-1:0] rd_data_1, rd_data_0;
    logic [NRD-1:0]    rd_busy_1, rd_busy_0;
    logic              any_busy_1, any_busy_0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] m1_regs [32];
    logic [31:0]   m1_busy;
    logic [DW-1:0] m0_regs [32];
    logic [31:0]   m0_busy;

    always #5 clk = ~clk;

    rf_multiport_sb #(
        .DATA_W(DW), .NUM_REGS(32), .ADDR_W(AW), .NUM_RD(NRD),
        .SP_IDX(2), .SP_RESET(32'h0000_0200), .BYPASS(1)
    ) u_byp (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_1),
        .rd_busy(rd_busy_1), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .any_busy(any_busy_1)
    );

    rf_multiport_sb #(
        .DATA_W(DW), .NUM_REGS(NR0), .ADDR_W(AW), .NUM_RD(NRD),
        .SP_IDX(2), .SP_RESET(32'h0000_0200), .BYPASS(0)
    ) u_nob (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_0),
        .rd_busy(rd_busy_0), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .any_busy(any_busy_0)
    );

    // Advance one edge, then idle all write/reserve ports.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        wa_en  = 1'b0;
        wb_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    function automatic logic [AW-1:0] pick();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, 31));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        set_rd(0, 5'd2); set_rd(1, 5'd0); set_rd(2, 5'd5); set_rd(3, 5'd31);
        #1;
        n_checks++; if (rd_data_1[0*DW +: DW] !== 32'h200) begin n_fail++; $display("FAIL reset_sp_byp got %h exp %h", rd_data_1[0*DW +: DW], 32'h200); end
        n_checks++; if (rd_data_0[0*DW +: DW] !== 32'h200) begin n_fail++; $display("FAIL reset_sp_nob got %h exp %h", rd_data_0[0*DW +: DW], 32'h200); end
        n_checks++; if (rd_data_1 !== {32'h0, 32'h0, 32'h0, 32'h200}) begin n_fail++; $display("FAIL reset_all_byp got %h", rd_data_1); end
        n_checks++; if ({rd_busy_1, any_busy_1, rd_busy_0, any_busy_0} !== 10'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", {rd_busy_1, any_busy_1, rd_busy_0, any_busy_0}); end
        // Load state, then reset one cycle later with writes pending.
        wa_en = 1'b1; wa_addr = 5'd2; wa_data = 32'hDEAD;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'd7;
        rsv_en = 1'b1; rsv_addr = 5'd6;
        next_cycle();
        #1;
        n_checks++; if (rd_data_0[0*DW +: DW] !== 32'hDEAD) begin n_fail++; $display("FAIL prerst_x2 got %h exp %h", rd_data_0[0*DW +: DW], 32'hDEAD); end
        n_checks++; if (rd_data_0[2*DW +: DW] !== 32'd7) begin n_fail++; $display("FAIL prerst_x5 got %h exp %h", rd_data_0[2*DW +: DW], 32'd7); end
        n_checks++; if (any_busy_0 !== 1'b1) begin n_fail++; $display("FAIL prerst_any got %b exp 1", any_busy_0); end
        rst = 1'b1;
        wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h123;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        next_cycle();
        rst = 1'b0;
        set_rd(1, 5'd7); set_rd(3, 5'd9);
        #1;
        n_checks++; if (rd_data_1 !== {32'h0, 32'h0, 32'h0, 32'h200}) begin n_fail++; $display("FAIL rerst_data_byp got %h", rd_data_1); end
        n_checks++; if (rd_data_0 !== {32'h0, 32'h0, 32'h0, 32'h200}) begin n_fail++; $display("FAIL rerst_data_nob got %h", rd_data_0); end
        n_checks++; if ({rd_busy_1, any_busy_1, rd_busy_0, any_busy_0} !== 10'b0) begin n_fail++; $display("FAIL rerst_busy got %b exp 0", {rd_busy_1, any_busy_1, rd_busy_0, any_busy_0}); end
    endtask

    task automatic test_x0();
        for (int p = 0; p < NRD; p++) set_rd(p, 5'd0);
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFF_FFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        #1;
        n_checks++; if (rd_data_1 !== '0) begin n_fail++; $display("FAIL x0_same_data got %h exp 0", rd_data_1); end
        n_checks++; if (rd_busy_1 !== '0) begin n_fail++; $display("FAIL x0_same_busy got %b exp 0", rd_busy_1); end
        next_cycle();
        #1;
        n_checks++; if ({rd_data_1, rd_data_0} !== '0) begin n_fail++; $display("FAIL x0_next_data got %h exp 0", {rd_data_1, rd_data_0}); end
        n_checks++; if ({any_busy_1, any_busy_0, rd_busy_1, rd_busy_0} !== '0) begin n_fail++; $display("FAIL x0_next_busy got %b exp 0", {any_busy_1, any_busy_0, rd_busy_1, rd_busy_0}); end
    endtask

    task automatic test_bypass();
        set_rd(0, 5'd3);
        wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h11;
        #1;
        n_checks++; if (rd_data_1[0*DW +: DW] !== 32'h11) begin n_fail++; $display("FAIL byp_same got %h exp %h", rd_data_1[0*DW +: DW], 32'h11); end
        n_checks++; if (rd_data_0[0*DW +: DW] !== 32'h0) begin n_fail++; $display("FAIL nob_same got %h exp %h", rd_data_0[0*DW +: DW], 32'h0); end
        next_cycle();
        #1;
        n_checks++; if (rd_data_1[0*DW +: DW] !== 32'h11) begin n_fail++; $display("FAIL byp_next got %h exp %h", rd_data_1[0*DW +: DW], 32'h11); end
        n_checks++; if (rd_data_0[0*DW +: DW] !== 32'h11) begin n_fail++; $display("FAIL nob_next got %h exp %h", rd_data_0[0*DW +: DW], 32'h11); end
    endtask

    task automatic test_dual_write();
        set_rd(1, 5'd4);
        wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'hA;
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hB;
        #1;
        n_checks++; if (rd_data_1[1*DW +: DW] !== 32'hB) begin n_fail++; $display("FAIL dual_same_byp got %h exp %h", rd_data_1[1*DW +: DW], 32'hB); end
        n_checks++; if (rd_data_0[1*DW +: DW] !== 32'h0) begin n_fail++; $display("FAIL dual_same_nob got %h exp %h", rd_data_0[1*DW +: DW], 32'h0); end
        next_cycle();
        #1;
        n_checks++; if (rd_data_1[1*DW +: DW] !== 32'hB) begin n_fail++; $display("FAIL dual_next_byp got %h exp %h", rd_data_1[1*DW +: DW], 32'hB); end
        n_checks++; if (rd_data_0[1*DW +: DW] !== 32'hB) begin n_fail++; $display("FAIL dual_next_nob got %h exp %h", rd_data_0[1*DW +: DW], 32'hB); end
    endtask

    task automatic test_scoreboard();
        set_rd(0, 5'd6);
        rsv_en = 1'b1; rsv_addr = 5'd6;
        #1;
        n_checks++; if ({rd_busy_1[0], any_busy_1} !== 2'b00) begin n_fail++; $display("FAIL rsv_same got %b exp 00", {rd_busy_1[0], any_busy_1}); end
        next_cycle();
        #1;
        n_checks++; if ({rd_busy_1[0], any_busy_1, rd_busy_0[0], any_busy_0} !== 4'b1111) begin n_fail++; $display("FAIL rsv_next got %b exp 1111", {rd_busy_1[0], any_busy_1, rd_busy_0[0], any_busy_0}); end
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h55;
        #1;
        n_checks++; if ({rd_busy_1[0], any_busy_1} !== 2'b01) begin n_fail++; $display("FAIL wb_clr_byp_busy got %b exp 01", {rd_busy_1[0], any_busy_1}); end
        n_checks++; if (rd_data_1[0*DW +: DW] !== 32'h55) begin n_fail++; $display("FAIL wb_clr_byp_data got %h exp %h", rd_data_1[0*DW +: DW], 32'h55); end
        n_checks++; if ({rd_busy_0[0], rd_data_0[0*DW +: DW]} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL wb_clr_nob got %h exp %h", {rd_busy_0[0], rd_data_0[0*DW +: DW]}, {1'b1, 32'h0}); end
        next_cycle();
        #1;
        n_checks++; if ({any_busy_1, any_busy_0, rd_busy_0[0]} !== 3'b000) begin n_fail++; $display("FAIL wb_clr_next got %b exp 000", {any_busy_1, any_busy_0, rd_busy_0[0]}); end
        n_checks++; if (rd_data_0[0*DW +: DW] !== 32'h55) begin n_fail++; $display("FAIL wb_clr_next_data got %h exp %h", rd_data_0[0*DW +: DW], 32'h55); end
        // Reserve, then reserve + return together: reservation wins.
        rsv_en = 1'b1; rsv_addr = 5'd6;
        next_cycle();
        rsv_en = 1'b1; rsv_addr = 5'd6;
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
        next_cycle();
        #1;
        n_checks++; if ({rd_busy_1[0], any_busy_1, rd_busy_0[0], any_busy_0} !== 4'b1111) begin n_fail++; $display("FAIL rsv_wins got %b exp 1111", {rd_busy_1[0], any_busy_1, rd_busy_0[0], any_busy_0}); end
        n_checks++; if (rd_data_0[0*DW +: DW] !== 32'h66) begin n_fail++; $display("FAIL rsv_wins_data got %h exp %h", rd_data_0[0*DW +: DW], 32'h66); end
        // Port A to a busy register stores data but leaves busy set.
        wa_en = 1'b1; wa_addr = 5'd6; wa_data = 32'h77;
        next_cycle();
        #1;
        n_checks++; if ({rd_busy_0[0], rd_data_0[0*DW +: DW]} !== {1'b1, 32'h77}) begin n_fail++; $display("FAIL wa_busy got %h exp %h", {rd_busy_0[0], rd_data_0[0*DW +: DW]}, {1'b1, 32'h77}); end
        wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h88;
        next_cycle();
        #1;
        n_checks++; if ({any_busy_1, any_busy_0} !== 2'b00) begin n_fail++; $display("FAIL final_clr got %b exp 00", {any_busy_1, any_busy_0}); end
    endtask

    task automatic test_out_of_range();
        set_rd(0, 5'd25); set_rd(1, 5'd26);
        wa_en = 1'b1; wa_addr = 5'd25; wa_data = 32'h99;
        rsv_en = 1'b1; rsv_addr = 5'd26;
        next_cycle();
        #1;
        n_checks++; if ({rd_data_0[0*DW +: DW], rd_busy_0[1], any_busy_0} !== {32'h0, 2'b00}) begin n_fail++; $display("FAIL oor_nob got %h exp 0", {rd_data_0[0*DW +: DW], rd_busy_0[1], any_busy_0}); end
        n_checks++; if ({rd_data_1[0*DW +: DW], rd_busy_1[1], any_busy_1} !== {32'h99, 2'b11}) begin n_fail++; $display("FAIL oor_byp got %h exp %h", {rd_data_1[0*DW +: DW], rd_busy_1[1], any_busy_1}, {32'h99, 2'b11}); end
    endtask

    task automatic test_multiport();
        logic [AW-1:0] a;
        logic [DW-1:0] e_d;
        logic          e_b;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m1_regs[i] = (i == 2) ? 32'h200 : 32'h0;
            m0_regs[i] = (i == 2) ? 32'h200 : 32'h0;
        end
        m1_busy = '0;
        m0_busy = '0;
        for (int c = 0; c < 1000; c++) begin
            wa_en  = 1'($urandom_range(0, 1)); wa_addr  = pick(); wa_data = $urandom();
            wb_en  = 1'($urandom_range(0, 1)); wb_addr  = pick(); wb_data = $urandom();
            rsv_en = 1'($urandom_range(0, 1)); rsv_addr = pick();
            for (int p = 0; p < NRD; p++) set_rd(p, pick());
            #1;
            for (int p = 0; p < NRD; p++) begin
                a = rd_addr[p*AW +: AW];
                e_d = '0; e_b = 1'b0;
                if (a != 0) begin
                    if (wb_en && wb_addr == a) begin
                        e_d = wb_data; e_b = 1'b0;
                    end else if (wa_en && wa_addr == a) begin
                        e_d = wa_data; e_b = m1_busy[a];
                    end else begin
                        e_d = m1_regs[a]; e_b = m1_busy[a];
                    end
                end
                n_checks++; if ({rd_busy_1[p], rd_data_1[p*DW +: DW]} !== {e_b, e_d}) begin n_fail++; $display("FAIL mp_byp c=%0d p=%0d got %h exp %h", c, p, {rd_busy_1[p], rd_data_1[p*DW +: DW]}, {e_b, e_d}); end
                e_d = '0; e_b = 1'b0;
                if (a != 0 && int'(a) < NR0) begin
                    e_d = m0_regs[a]; e_b = m0_busy[a];
                end
                n_checks++; if ({rd_busy_0[p], rd_data_0[p*DW +: DW]} !== {e_b, e_d}) begin n_fail++; $display("FAIL mp_nob c=%0d p=%0d got %h exp %h", c, p, {rd_busy_0[p], rd_data_0[p*DW +: DW]}, {e_b, e_d}); end
            end
            n_checks++; if ({any_busy_1, any_busy_0} !== {|m1_busy, |m0_busy}) begin n_fail++; $display("FAIL mp_any c=%0d got %b exp %b", c, {any_busy_1, any_busy_0}, {|m1_busy, |m0_busy}); end
            if (wa_en && wa_addr != 0) m1_regs[wa_addr] = wa_data;
            if (wb_en && wb_addr != 0) begin m1_regs[wb_addr] = wb_data; m1_busy[wb_addr] = 1'b0; end
            if (rsv_en && rsv_addr != 0) m1_busy[rsv_addr] = 1'b1;
            if (wa_en && wa_addr != 0 && int'(wa_addr) < NR0) m0_regs[wa_addr] = wa_data;
            if (wb_en && wb_addr != 0 && int'(wb_addr) < NR0) begin m0_regs[wb_addr] = wb_data; m0_busy[wb_addr] = 1'b0; end
            if (rsv_en && rsv_addr != 0 && int'(rsv_addr) < NR0) m0_busy[rsv_addr] = 1'b1;
            next_cycle();
        end
    endtask

    initial begin
        rst = 1'b1;
        rd_addr = '0;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        test_reset();
        next_cycle();
        test_x0();
        next_cycle();
        test_bypass();
        next_cycle();
        test_dual_write();
        next_cycle();
        test_scoreboard();
        next_cycle();
        test_out_of_range();
        next_cycle();
        test_multiport();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
